bus_arbiter: RTL
================

// Module: bus_arbiter
// PURPOSE
//  Shares the serial system bus between two masters (M1, M2) in front of the MasterIn/MasterOut paths.
//  Takes request + slave select + burst length from each master and grants the bus to one master.
//  Drives the slave select, data-mux select and burst_num seen by the slaves.
//  Releases the bus on completion, with a one-cycle turnaround between owners.
// PARAMETERS
//  NUM_SLAVES   3     number of valid slave selects (0..NUM_SLAVES-1)
//  SEL_W        2     slave select width
//  BURST_W      12    burst length width (0 = single transfer)
//  TIMEOUT_CYC  1024  max grant cycles before forced release (ARB_TIMEOUT_EN only)
// PORTS
//  clk           in   1        system clock, rising edge
//  reset         in   1        asynchronous reset, active-high
//  m1_req        in   1        M1 bus request, level; held until granted
//  m1_slave_sel  in   SEL_W    M1 target slave
//  m1_burst      in   BURST_W  M1 burst_num
//  m1_done       in   1        M1 transfer-complete pulse (tx_done/rx_done of M1)
//  m2_req        in   1        M2 bus request, level
//  m2_slave_sel  in   SEL_W    M2 target slave
//  m2_burst      in   BURST_W  M2 burst_num
//  m2_done       in   1        M2 transfer-complete pulse
//  m1_grant      out  1        M1 owns bus
//  m2_grant      out  1        M2 owns bus
//  bus_busy      out  1        bus owned or in turnaround
//  master_sel    out  1        data mux select: 0 = M1, 1 = M2; holds last owner
//  slave_sel     out  SEL_W    registered slave select of current owner
//  burst_num     out  BURST_W  registered burst length of current owner
//  sel_err       out  1        1-cycle pulse: request rejected, slave_sel >= NUM_SLAVES
//  timeout       out  1        1-cycle pulse: forced release (ARB_TIMEOUT_EN only)
// BEHAVIOUR
//  Reset (async, immediate): state = IDLE; last_owner = M2, so M1 wins the first tie.
//   All outputs 0. Reset mid-grant drops the grant at once; no done is expected afterwards.
//  States: IDLE -> GNT1 | GNT2 -> TURN -> IDLE.
//  IDLE: sample requests.
//   One request only: grant it.
//   Both requests: grant the master that is not last_owner (round-robin).
//   The grant is registered, so grant rises 1 cycle after req is seen.
//   slave_sel, burst_num, master_sel and last_owner are latched in the same edge as the grant.
//   They are stable for the whole grant.
//  Invalid slave_sel: that request is refused.
//   sel_err pulses 1 cycle; state stays IDLE.
//   If the other master has a valid request, it is granted in the same cycle.
//   An invalid request that stays asserted pulses sel_err again every IDLE cycle.
//  GNT1/GNT2 exit, on the first cycle where the owner's done = 1 or the owner's req = 0:
//   grant drops next edge; go to TURN. Done and req-drop in the same cycle give a single release.
//  Done from the non-owner: ignored in every state. Done in IDLE/TURN: ignored.
//  Other master's req during a grant: it waits; no preemption.
//  TURN: exactly 1 cycle, no grant, bus_busy = 1; then IDLE.
//   Back-to-back handover latency: done -> next grant = 3 edges (release, TURN, grant).
//  bus_busy = 1 in GNT1, GNT2 and TURN; 0 in IDLE.
//  Invariant: m1_grant & m2_grant never 1 together.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined:
//   cycle counter, width clog2(TIMEOUT_CYC), is cleared on grant and counts each grant cycle.
//   When it reaches TIMEOUT_CYC-1 without done/req-drop: force release to TURN and pulse timeout for 1 cycle.
//   Done arriving in the same cycle as the limit counts as normal release; no timeout pulse.
//  ARB_TIMEOUT_EN undefined: no counter; timeout tied 0; a grant is held until done or req drop.
// TESTING
//  Reset, then m1_req=1, sel=1, burst=0 -> m1_grant=1 next cycle, slave_sel=1, burst_num=0, bus_busy=1.
//  m1_done pulse -> m1_grant=0 next edge; TURN 1 cycle (bus_busy=1); then IDLE, bus_busy=0.
//  Both req same cycle after reset -> M1 granted.
//   On M1 done with M2 still requesting -> M2 granted 3 edges later, master_sel=1.
//   Next tie -> M1.
//  m2_req with sel=3 (NUM_SLAVES=3) -> sel_err pulse each IDLE cycle, no grant.
//   With m1_req=1 in the same cycle -> M1 granted.
//  Reset asserted mid-GNT2, burst=3 -> all outputs 0 immediately.
//   After release, m1_req -> M1 granted first (last_owner = M2).
//  ARB_TIMEOUT_EN, TIMEOUT_CYC=16, M1 granted, no done -> timeout pulse and release after 16 grant cycles.
//   Without the macro, the grant is still held at 100 cycles.

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master arbiter for the serial system bus.
//   Grants the bus to M1 or M2 and drives the slave select, the data-mux select
//   and burst_num seen by the slaves. After each release there is one
//   turnaround cycle before the next owner. Simultaneous requests alternate
//   round-robin.
// Optional build macro: ARB_TIMEOUT_EN. When it is defined, a grant held for
//   TIMEOUT_CYC cycles without done or req-drop is released by force.
// Ports:
//   clk, reset                     clock (rising edge) and async active-high reset
//   m1_req/m1_slave_sel/m1_burst   M1 request, target slave and burst length
//   m1_done                        M1 transfer-complete pulse
//   m2_req/m2_slave_sel/m2_burst   M2 request, target slave and burst length
//   m2_done                        M2 transfer-complete pulse
//   m1_grant, m2_grant             ownership flags; never high together
//   bus_busy                       bus is owned or in turnaround
//   master_sel                     data mux select (0 = M1, 1 = M2); holds the last owner
//   slave_sel, burst_num           latched from the owner when the grant is made
//   sel_err                        1-cycle pulse: a request was refused for an out-of-range slave select
//   timeout                        1-cycle pulse: forced release (0 when ARB_TIMEOUT_EN is undefined)
module bus_arbiter #(
    parameter int NUM_SLAVES  = 3,
    parameter int SEL_W       = 2,
    parameter int BURST_W     = 12,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               m1_req,
    input  logic [SEL_W-1:0]   m1_slave_sel,
    input  logic [BURST_W-1:0] m1_burst,
    input  logic               m1_done,
    input  logic               m2_req,
    input  logic [SEL_W-1:0]   m2_slave_sel,
    input  logic [BURST_W-1:0] m2_burst,
    input  logic               m2_done,
    output logic               m1_grant,
    output logic               m2_grant,
    output logic               bus_busy,
    output logic               master_sel,
    output logic [SEL_W-1:0]   slave_sel,
    output logic [BURST_W-1:0] burst_num,
    output logic               sel_err,
    output logic               timeout
);

    typedef enum logic [1:0] {IDLE, GNT1, GNT2, TURN} state_t;

    // One extra bit so that NUM_SLAVES == 2**SEL_W still compares correctly.
    localparam logic [SEL_W:0] NUM_SL = NUM_SLAVES[SEL_W:0];

    state_t state, state_nxt;
    logic   last_owner;            // 0 = M1, 1 = M2
    logic   v1, v2;                // valid requests
    logic   load, load_m2;         // grant made this cycle, and to which master
    logic   err_nxt, to_nxt;
    logic   limit;

    assign v1 = m1_req && ({1'b0, m1_slave_sel} < NUM_SL);
    assign v2 = m2_req && ({1'b0, m2_slave_sel} < NUM_SL);

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [CNT_W-1:0] cnt;

    // The counter is 0 on the first grant cycle, so the limit is reached on
    // the TIMEOUT_CYC-th cycle of the grant.
    assign limit = (cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= '0;
        else if (state == GNT1 || state == GNT2)
            cnt <= cnt + 1'b1;
    end
`else
    assign limit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        load_m2   = 1'b0;
        err_nxt   = 1'b0;
        to_nxt    = 1'b0;
        case (state)
            IDLE: begin
                // A refused request never blocks a valid request from the other master.
                err_nxt = (m1_req && !v1) || (m2_req && !v2);
                if (v1 && v2) begin
                    load    = 1'b1;
                    load_m2 = !last_owner;
                end else if (v1 || v2) begin
                    load    = 1'b1;
                    load_m2 = v2;
                end
                if (load)
                    state_nxt = load_m2 ? GNT2 : GNT1;
            end
            GNT1: begin
                // Done or a dropped request releases normally, even when the limit is reached in the same cycle.
                if (m1_done || !m1_req) begin
                    state_nxt = TURN;
                end else if (limit) begin
                    state_nxt = TURN;
                    to_nxt    = 1'b1;
                end
            end
            GNT2: begin
                if (m2_done || !m2_req) begin
                    state_nxt = TURN;
                end else if (limit) begin
                    state_nxt = TURN;
                    to_nxt    = 1'b1;
                end
            end
            default: state_nxt = IDLE;   // TURN is a single cycle
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_owner <= 1'b1;          // so that M1 wins the first tie
            master_sel <= 1'b0;
            slave_sel  <= '0;
            burst_num  <= '0;
            sel_err    <= 1'b0;
        end else begin
            state   <= state_nxt;
            sel_err <= err_nxt;
            if (load) begin
                last_owner <= load_m2;
                master_sel <= load_m2;
                slave_sel  <= load_m2 ? m2_slave_sel : m1_slave_sel;
                burst_num  <= load_m2 ? m2_burst : m1_burst;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            timeout <= 1'b0;
        else
            timeout <= to_nxt;
    end
`else
    assign timeout = 1'b0;
`endif

    assign m1_grant = (state == GNT1);
    assign m2_grant = (state == GNT2);
    assign bus_busy = (state != IDLE);

endmodule
